// File: rtl/eth_pause_pkg.sv
// Shared constants, FSM state type and PAUSE frame byte builder for the
// tx_clk PAUSE scheduler.
package eth_pause_pkg;

  localparam logic [47:0] PAUSE_DA        = 48'h0180C2000001;
  localparam logic [15:0] PAUSE_ETHERTYPE = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE    = 16'h0001;
  localparam int          PAUSE_FRAME_LEN = 60;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA     = 2'd1,
    ST_PAUSE_TX = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_XOFF = 2'd1,
    REQ_XON  = 2'd2
  } pause_req_e;

  // Header occupies bytes 0..17 (DA, SA, type, opcode, quanta); the rest is pad.
  function automatic logic [7:0] pause_frame_byte(input logic [5:0]  idx,
                                                  input logic [47:0] src_mac,
                                                  input logic [15:0] quanta);
    logic [143:0] hdr;
    hdr = {PAUSE_DA, src_mac, PAUSE_ETHERTYPE, PAUSE_OPCODE, quanta};
    hdr = hdr << {idx, 3'b000};
    if (idx < 6'd18) pause_frame_byte = hdr[143:136];
    else             pause_frame_byte = 8'h00;
  endfunction

endpackage

// File: rtl/eth_pause_quanta_timer.sv
// Quantum prescaler plus 16-bit loadable counter. Down mode saturates at 0
// (remote pause timer); up mode counts quanta (XOFF refresh counter).
module eth_pause_quanta_timer #(
  parameter int QUANTUM_CYCLES          = 64,
  parameter bit COUNT_UP                = 1'b0,
  parameter bit CLEAR_PRESCALER_ON_LOAD = 1'b1
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic        tick_en,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        cnt_en,
  output logic        tick,
  output logic [15:0] count
);

  localparam int            PW       = (QUANTUM_CYCLES > 1) ? $clog2(QUANTUM_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(QUANTUM_CYCLES - 1);

  logic [PW-1:0] prescaler;

  assign tick = tick_en && (prescaler == PRE_LAST);

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst)                                 prescaler <= '0;
    else if (load && CLEAR_PRESCALER_ON_LOAD)   prescaler <= '0;
    else if (tick)                              prescaler <= '0;
    else if (tick_en)                           prescaler <= prescaler + 1'b1;
  end

  // A load wins over a tick landing in the same cycle.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && cnt_en) begin
      if (COUNT_UP)           count <= count + 16'd1;
      else if (count != '0)   count <= count - 16'd1;
    end
  end

endmodule

// File: rtl/eth_mac_pause_tx_sched.sv
// Frame-boundary arbiter between TX FIFO data and locally generated
// 802.3x XOFF/XON frames, with a remote PAUSE hold-off timer.
module eth_mac_pause_tx_sched
  import eth_pause_pkg::*;
#(
  parameter int QUANTUM_CYCLES  = 64,
  parameter bit ENABLE_TX_PAUSE = 1'b1,
  parameter bit ENABLE_RX_PAUSE = 1'b1
) (
  input  logic         tx_clk,
  input  logic         tx_rst,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tuser,
  output logic [7:0]   m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         m_axis_tuser,
  input  logic         tick_en,
  input  logic         xoff_level,
  input  logic         rx_pause_valid,
  input  logic [15:0]  rx_pause_quanta,
  input  logic [47:0]  cfg_src_mac,
  input  logic [15:0]  cfg_pause_quanta,
  input  logic [15:0]  cfg_refresh_quanta,
  input  logic         cfg_tx_pause_enable,
  input  logic         cfg_rx_pause_enable,
  output logic         stat_paused,
  output logic         stat_xoff_sent,
  output logic         stat_xon_sent,
  output sched_state_e dbg_state
);

  // Handshake: a beat transfers on a cycle where tvalid && tready; tvalid,
  // once high in PAUSE_TX, holds with stable data until the transfer.

  sched_state_e state, state_nxt;
  pause_req_e   pending;
  logic [5:0]   byte_cnt;
  logic [15:0]  frame_quanta;
  logic         frame_is_xoff;
  logic         xoff_q;
  logic         take_req;
  logic         tx_en, xoff_rise, xoff_fall;
  logic         refresh_hit, pause_last;
  logic [15:0]  remote_cnt, refresh_cnt;

  assign tx_en      = ENABLE_TX_PAUSE && cfg_tx_pause_enable;
  assign xoff_rise  = tx_en && xoff_level && !xoff_q;
  assign xoff_fall  = tx_en && !xoff_level && xoff_q;
  assign pause_last = (byte_cnt == 6'(PAUSE_FRAME_LEN - 1));

  generate
    if (ENABLE_RX_PAUSE) begin : g_rx
      logic unused_rx_tick;
      eth_pause_quanta_timer #(
        .QUANTUM_CYCLES(QUANTUM_CYCLES), .COUNT_UP(1'b0), .CLEAR_PRESCALER_ON_LOAD(1'b1)
      ) u_remote (
        .tx_clk, .tx_rst, .tick_en,
        .load(rx_pause_valid && cfg_rx_pause_enable), .load_value(rx_pause_quanta),
        .cnt_en(1'b1), .tick(unused_rx_tick), .count(remote_cnt)
      );
    end else begin : g_no_rx
      assign remote_cnt = '0;
    end

    // Refresh prescaler free-runs; only the quantum count is cleared per frame.
    if (ENABLE_TX_PAUSE) begin : g_tx
      logic unused_ref_tick;
      eth_pause_quanta_timer #(
        .QUANTUM_CYCLES(QUANTUM_CYCLES), .COUNT_UP(1'b1), .CLEAR_PRESCALER_ON_LOAD(1'b0)
      ) u_refresh (
        .tx_clk, .tx_rst, .tick_en,
        .load(take_req), .load_value(16'd0),
        .cnt_en(tx_en && xoff_level && (cfg_refresh_quanta != '0) && (refresh_cnt < cfg_refresh_quanta)),
        .tick(unused_ref_tick), .count(refresh_cnt)
      );
    end else begin : g_no_tx
      assign refresh_cnt = '0;
    end
  endgenerate

  // Suppressed in the take cycle: the count still shows the old value there.
  assign refresh_hit = tx_en && xoff_level && (cfg_refresh_quanta != '0) &&
                       (refresh_cnt >= cfg_refresh_quanta) && !take_req;

  assign stat_paused = (remote_cnt != '0);
  assign dbg_state   = state;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      xoff_q  <= 1'b0;
      pending <= REQ_NONE;
    end else begin
      xoff_q <= xoff_level;
      if (xoff_fall)                      pending <= REQ_XON;
      else if (xoff_rise || refresh_hit)  pending <= REQ_XOFF;
      else if (take_req)                  pending <= REQ_NONE;
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      frame_quanta  <= '0;
      frame_is_xoff <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_req) begin
        byte_cnt      <= '0;
        frame_is_xoff <= (pending == REQ_XOFF);
        frame_quanta  <= (pending == REQ_XOFF) ? cfg_pause_quanta : 16'd0;
      end else if (state == ST_PAUSE_TX && m_axis_tready && !pause_last) begin
        byte_cnt <= byte_cnt + 6'd1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    take_req       = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s_axis_tready  = 1'b0;
    stat_xoff_sent = 1'b0;
    stat_xon_sent  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pending != REQ_NONE) begin
          state_nxt = ST_PAUSE_TX;
          take_req  = 1'b1;
        end else if (s_axis_tvalid && remote_cnt == '0) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nxt = ST_IDLE;
      end
      ST_PAUSE_TX: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = pause_frame_byte(byte_cnt, cfg_src_mac, frame_quanta);
        m_axis_tlast  = pause_last;
        if (m_axis_tready && pause_last) begin
          state_nxt      = ST_IDLE;
          stat_xoff_sent = frame_is_xoff;
          stat_xon_sent  = !frame_is_xoff;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_mac_pause_tx_sched.sv
// Scoreboard bench for eth_mac_pause_tx_sched: data pass-through, XOFF/XON
// generation, boundary arbitration, remote pause, refresh, backpressure, reset.
module tb_eth_mac_pause_tx_sched;

  logic         tx_clk = 1'b0;
  logic         tx_rst;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic         tick_en, xoff_level, rx_pause_valid;
  logic [15:0]  rx_pause_quanta;
  logic [47:0]  cfg_src_mac;
  logic [15:0]  cfg_pause_quanta, cfg_refresh_quanta;
  logic         cfg_tx_pause_enable, cfg_rx_pause_enable;
  logic         stat_paused, stat_xoff_sent, stat_xon_sent;
  eth_pause_pkg::sched_state_e dbg_state;

  eth_mac_pause_tx_sched #(
    .QUANTUM_CYCLES(64), .ENABLE_TX_PAUSE(1'b1), .ENABLE_RX_PAUSE(1'b1)
  ) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .tick_en(tick_en), .xoff_level(xoff_level),
    .rx_pause_valid(rx_pause_valid), .rx_pause_quanta(rx_pause_quanta),
    .cfg_src_mac(cfg_src_mac), .cfg_pause_quanta(cfg_pause_quanta),
    .cfg_refresh_quanta(cfg_refresh_quanta),
    .cfg_tx_pause_enable(cfg_tx_pause_enable), .cfg_rx_pause_enable(cfg_rx_pause_enable),
    .stat_paused(stat_paused), .stat_xoff_sent(stat_xoff_sent), .stat_xon_sent(stat_xon_sent),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #4 tx_clk = ~tx_clk;

  int cyc = 0;
  always @(posedge tx_clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- scoreboard / monitor ----------------
  // Entry layout: {tuser, tlast, tdata}
  logic [9:0] exp_q[$];
  int sof_q[$];
  int hs_total = 0;
  int frame_beats = 0;
  bit prev_hs_last = 1'b0;
  int xoff_pulses = 0;
  int xon_pulses = 0;
  int paused_cycles = 0;

  always @(negedge tx_clk) begin
    logic [9:0] exp_v, got_v;
    if (tx_rst) begin
      frame_beats  = 0;
      prev_hs_last = 1'b0;
    end else begin
      if (prev_hs_last) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap: tvalid=%b required=0 at cycle %0d", m_axis_tvalid, cyc);
        end
      end
      prev_hs_last = 1'b0;
      if (stat_paused === 1'b1) paused_cycles++;
      if (stat_xoff_sent === 1'b1) begin
        xoff_pulses++;
        checks++;
        if (!(m_axis_tvalid && m_axis_tready && m_axis_tlast)) begin
          failures++;
          $display("FAIL xoff_pulse_align: pulse without last-beat handshake at cycle %0d", cyc);
        end
      end
      if (stat_xon_sent === 1'b1) begin
        xon_pulses++;
        checks++;
        if (!(m_axis_tvalid && m_axis_tready && m_axis_tlast)) begin
          failures++;
          $display("FAIL xon_pulse_align: pulse without last-beat handshake at cycle %0d", cyc);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        if (frame_beats == 0) sof_q.push_back(cyc);
        hs_total++;
        frame_beats++;
        got_v = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got=%h with empty expected queue at cycle %0d", got_v, cyc);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin
            failures++;
            $display("FAIL beat: got {user,last,data}=%h required=%h at cycle %0d", got_v, exp_v, cyc);
          end
        end
        if (m_axis_tlast === 1'b1) begin
          frame_beats  = 0;
          prev_hs_last = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pause(input bit is_xoff, input int nbytes);
    logic [143:0] hdr;
    logic [15:0]  q;
    logic [7:0]   b;
    q   = is_xoff ? cfg_pause_quanta : 16'h0000;
    hdr = {48'h0180C2000001, cfg_src_mac, 16'h8808, 16'h0001, q};
    for (int i = 0; i < nbytes; i++) begin
      b = (i < 18) ? 8'(hdr >> (8 * (17 - i))) : 8'h00;
      exp_q.push_back({1'b0, (i == 59), b});
    end
  endtask

  task automatic send_frame(input int len);
    logic [7:0] d[$];
    logic       u[$];
    bit         accepted;
    for (int i = 0; i < len; i++) begin
      d.push_back(8'($urandom_range(0, 255)));
      u.push_back((i == len - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      exp_q.push_back({u[i], (i == len - 1), d[i]});
    end
    for (int i = 0; i < len; i++) begin
      s_axis_tdata  = d[i];
      s_axis_tuser  = u[i];
      s_axis_tlast  = (i == len - 1);
      s_axis_tvalid = 1'b1;
      accepted = 1'b0;
      for (int w = 0; w < 3000 && !accepted; w++) begin
        @(negedge tx_clk);
        if (s_axis_tready === 1'b1 && m_axis_tready === 1'b1) accepted = 1'b1;
      end
      if (!accepted) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: beat %0d of %0d never accepted", i, len);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d[i]) begin
        failures++;
        $display("FAIL passthru_latency: m_valid=%b m_data=%h required 1/%h", m_axis_tvalid, m_axis_tdata, d[i]);
      end
      @(posedge tx_clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < budget) begin
      @(negedge tx_clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d expected beats never appeared", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge tx_clk);
    #1;
  endtask

  task automatic wait_beats(input int n);
    int w;
    w = 0;
    while (frame_beats < n && w < 2000) begin
      @(posedge tx_clk); #1;
      w++;
    end
  endtask

  task automatic pulse_rx_pause(input logic [15:0] q, output int load_cyc);
    rx_pause_quanta = q;
    rx_pause_valid  = 1'b1;
    @(posedge tx_clk); #1;
    load_cyc       = cyc;
    rx_pause_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tx_rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    m_axis_tready = 1'b1; tick_en = 1'b1; xoff_level = 1'b0;
    rx_pause_valid = 1'b0; rx_pause_quanta = '0;
    cfg_src_mac = 48'h020000000001; cfg_pause_quanta = 16'hFFFF; cfg_refresh_quanta = '0;
    cfg_tx_pause_enable = 1'b1; cfg_rx_pause_enable = 1'b1;
    repeat (3) @(negedge tx_clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000) begin
      failures++; $display("FAIL reset_m_ctrl: got=%b required=000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser});
    end
    checks++;
    if (m_axis_tdata !== 8'h00) begin
      failures++; $display("FAIL reset_m_data: got=%h required=00", m_axis_tdata);
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++; $display("FAIL reset_s_ready: got=%b required=0", s_axis_tready);
    end
    checks++;
    if ({stat_paused, stat_xoff_sent, stat_xon_sent} !== 3'b000) begin
      failures++; $display("FAIL reset_stats: got=%b required=000", {stat_paused, stat_xoff_sent, stat_xon_sent});
    end
    checks++;
    if (dbg_state !== eth_pause_pkg::ST_IDLE) begin
      failures++; $display("FAIL reset_state: got=%0d required=IDLE", dbg_state);
    end
    @(posedge tx_clk); #1;
    tx_rst = 1'b0;
    repeat (2) @(posedge tx_clk); #1;
  endtask

  task automatic test_passthrough();
    int h0;
    h0 = hs_total;
    send_frame(64);
    wait_drain(200);
    checks++;
    if (hs_total - h0 != 64) begin
      failures++; $display("FAIL passthru_len: got=%0d beats required=64", hs_total - h0);
    end
    checks++;
    if (xoff_pulses != 0 || xon_pulses != 0) begin
      failures++; $display("FAIL passthru_stats: xoff=%0d xon=%0d required 0/0", xoff_pulses, xon_pulses);
    end
  endtask

  task automatic test_xoff_xon();
    push_pause(1'b1, 60);
    xoff_level = 1'b1;
    wait_drain(300);
    checks++;
    if (xoff_pulses != 1) begin
      failures++; $display("FAIL xoff_pulses: got=%0d required=1", xoff_pulses);
    end
    push_pause(1'b0, 60);
    xoff_level = 1'b0;
    wait_drain(300);
    checks++;
    if (xon_pulses != 1 || xoff_pulses != 1) begin
      failures++; $display("FAIL xon_pulses: xon=%0d xoff=%0d required 1/1", xon_pulses, xoff_pulses);
    end
  endtask

  task automatic test_boundary();
    sof_q.delete();
    fork
      begin
        send_frame(100);
        send_frame(20);
      end
      begin
        wait_beats(10);
        push_pause(1'b1, 60);
        xoff_level = 1'b1;
      end
    join
    wait_drain(500);
    checks++;
    if (sof_q.size() != 3) begin
      failures++; $display("FAIL boundary_frames: got=%0d frames required=3", sof_q.size());
    end else begin
      checks++;
      if (sof_q[1] - sof_q[0] != 101) begin
        failures++; $display("FAIL boundary_xoff_start: got offset=%0d required=101", sof_q[1] - sof_q[0]);
      end
      checks++;
      if (sof_q[2] - sof_q[1] != 61) begin
        failures++; $display("FAIL boundary_data_start: got offset=%0d required=61", sof_q[2] - sof_q[1]);
      end
    end
    push_pause(1'b0, 60);
    xoff_level = 1'b0;
    wait_drain(300);
  endtask

  task automatic test_remote_pause();
    int load_cyc;
    sof_q.delete();
    paused_cycles = 0;
    load_cyc = 0;
    fork
      begin
        send_frame(40);
        send_frame(16);
      end
      begin
        wait_beats(5);
        pulse_rx_pause(16'd2, load_cyc);
      end
    join
    wait_drain(400);
    checks++;
    if (paused_cycles != 128) begin
      failures++; $display("FAIL paused_cycles: got=%0d required=128", paused_cycles);
    end
    checks++;
    if (sof_q.size() != 2 || sof_q[sof_q.size() - 1] - load_cyc != 129) begin
      failures++;
      $display("FAIL pause_hold: frames=%0d release offset=%0d required 2/129", sof_q.size(),
               (sof_q.size() != 0) ? sof_q[sof_q.size() - 1] - load_cyc : -1);
    end
    // Reload with zero releases a held frame on the next cycle.
    sof_q.delete();
    pulse_rx_pause(16'd20, load_cyc);
    fork
      send_frame(16);
      begin
        repeat (50) @(negedge tx_clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || stat_paused !== 1'b1) begin
          failures++; $display("FAIL pause_held: tvalid=%b paused=%b required 0/1", m_axis_tvalid, stat_paused);
        end
        @(posedge tx_clk); #1;
        pulse_rx_pause(16'd0, load_cyc);
      end
    join
    wait_drain(200);
    checks++;
    if (sof_q.size() != 1 || sof_q[0] - load_cyc != 1) begin
      failures++;
      $display("FAIL zero_reload: frames=%0d offset=%0d required 1/1", sof_q.size(),
               (sof_q.size() != 0) ? sof_q[0] - load_cyc : -1);
    end
    checks++;
    if (stat_paused !== 1'b0) begin
      failures++; $display("FAIL zero_reload_paused: got=%b required=0", stat_paused);
    end
  endtask

  task automatic test_refresh();
    int x0;
    x0 = xoff_pulses;
    sof_q.delete();
    cfg_refresh_quanta = 16'd4;
    push_pause(1'b1, 60);
    push_pause(1'b1, 60);
    push_pause(1'b1, 60);
    xoff_level = 1'b1;
    wait_drain(1500);
    xoff_level = 1'b0;
    push_pause(1'b0, 60);
    wait_drain(300);
    cfg_refresh_quanta = 16'd0;
    checks++;
    if (xoff_pulses - x0 != 3) begin
      failures++; $display("FAIL refresh_count: got=%0d required=3", xoff_pulses - x0);
    end
    checks++;
    if (sof_q.size() < 3) begin
      failures++; $display("FAIL refresh_frames: got=%0d required>=3", sof_q.size());
    end else begin
      checks++;
      if (sof_q[2] - sof_q[1] != 256) begin
        failures++; $display("FAIL refresh_period: got=%0d required=256", sof_q[2] - sof_q[1]);
      end
      checks++;
      if (sof_q[1] - sof_q[0] < 193 || sof_q[1] - sof_q[0] > 258) begin
        failures++; $display("FAIL refresh_first: got=%0d required 193..258", sof_q[1] - sof_q[0]);
      end
    end
  endtask

  task automatic test_backpressure_reset();
    int x0, n0, h0;
    bit done;
    x0 = xoff_pulses;
    done = 1'b0;
    push_pause(1'b1, 60);
    xoff_level = 1'b1;
    fork
      begin
        wait_drain(1000);
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          @(posedge tx_clk); #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    checks++;
    if (xoff_pulses - x0 != 1) begin
      failures++; $display("FAIL bp_xoff_pulse: got=%0d required=1", xoff_pulses - x0);
    end
    // XON frame cut by reset after 30 beats.
    n0 = xon_pulses;
    push_pause(1'b0, 30);
    xoff_level = 1'b0;
    wait_beats(30);
    tx_rst = 1'b1;
    h0 = hs_total;
    @(negedge tx_clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'h000) begin
      failures++; $display("FAIL rst_mid_outputs: got=%h required=000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end
    checks++;
    if ({s_axis_tready, stat_paused, stat_xoff_sent, stat_xon_sent} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_ready_stats: got=%b required=0000", {s_axis_tready, stat_paused, stat_xoff_sent, stat_xon_sent});
    end
    repeat (3) @(posedge tx_clk); #1;
    tx_rst = 1'b0;
    repeat (200) @(posedge tx_clk); #1;
    checks++;
    if (hs_total != h0 || exp_q.size() != 0) begin
      failures++; $display("FAIL rst_no_resume: beats after reset=%0d pending expected=%0d required 0/0", hs_total - h0, exp_q.size());
    end
    checks++;
    if (xon_pulses != n0) begin
      failures++; $display("FAIL rst_xon_pulse: got=%0d required=%0d", xon_pulses, n0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_xoff_xon();
    test_boundary();
    test_remote_pause();
    test_refresh();
    test_backpressure_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
